decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline.
- Consumes the 64-bit IF/ID word from fetch as {pc_plus4[63:32], instruction[31:0]}.
- Drives the registered ID/EX bundle expected by the execute stage.
- Contains the 32x32 register file with a write-back port, main control decode, sign extension, load-use hazard detection and branch-flush bubble insertion.

Parameters:
- NUM_REGS, 32, number of architectural registers (address width fixed at 5).
- RESET_PC_PLUS4, 32'd0, value of out_incremented_PC after reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- IF_ID  input  64  {pc_plus4, instruction} from fetch.
- flush  input  1  branch taken in MEM; squash the current decode.
- ex_mem_read  input  1  the instruction now in EX is a load (its M[1]).
- ex_rt  input  5  destination rt of the instruction now in EX.
- wb_reg_write  input  1  write-back enable.
- wb_write_reg  input  5  write-back destination.
- wb_write_data  input  32  write-back data.
- stall  output  1  combinational; freezes PC and IF_ID when high.
- out_WB  output  2  {RegWrite, MemtoReg}.
- out_M  output  3  {Branch, MemRead, MemWrite}.
- out_EX  output  4  {ALUOp[1:0], RegDst, ALUSrc}.
- out_incremented_PC  output  32  registered pc_plus4.
- out_regData1  output  32  registered rs data.
- out_regData2  output  32  registered rt data.
- out_sign_extended_offset  output  32  registered sign-extended imm.
- out_rs, out_rt, out_rd  output  5 each  registered instr[25:21], [20:16], [15:11].

Behaviour:
- Field decode: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Control decode, as {WB,M,EX}:
  - R-type op 0x00: 10,000,1010
  - lw 0x23: 11,010,0001
  - sw 0x2B: 00,001,0001
  - beq 0x04: 00,100,0100
  - addi 0x08: 10,000,0001
  - any other opcode: 00,000,0000 (NOP). instruction 32'h0 therefore decodes as a harmless R-type sll; no special case.
- Sign extension: {{16{imm[15]}}, imm}.
- Register file:
  - Write at posedge clk when wb_reg_write=1 and wb_write_reg!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Combinational reads with write-first bypass: if wb_reg_write=1, wb_write_reg!=0 and wb_write_reg equals rs (rt), the read returns wb_write_data in the same cycle.
- stall (combinational) = ex_mem_read && ex_rt!=0 && (ex_rt==rs || ex_rt==rt) && !flush.
- ID/EX register update at posedge clk, in priority order:
  1. reset: all out_* = 0 except out_incremented_PC = RESET_PC_PLUS4; all 32 registers cleared to 0.
  2. flush: bubble, all out_* = 0. A register-file write in the same cycle still occurs.
  3. stall: bubble, all out_* = 0. IF_ID is held by fetch, so the same instruction is re-decoded next cycle.
  4. otherwise: load decoded control, pc_plus4, read data, sign-extended imm, rs/rt/rd.
- Latency: one cycle from IF_ID to out_*.
- Stall lasts exactly one cycle per load-use, because the bubble clears ex_mem_read on the next cycle.
- Reset mid-stall: reset wins; stall may assert combinationally but outputs are held at reset values.
- Reset and a write-back in the same cycle: reset wins; the write is discarded.
- No arithmetic overflow paths; widths are exact, no truncation.

Test Plan:
- Reset: reset=1 for 2 cycles with IF_ID=64'h00000004_8C220008 -> all out_* = 0, stall=0; the cycle after release, out_WB=2'b11, out_M=3'b010, out_EX=4'b0001, out_incremented_PC=4, out_sign_extended_offset=8, out_rs=1, out_rt=2.
- Write-back and bypass: wb write r5=32'hDEADBEEF while decoding add r3,r5,r0 (32'h00A01820) -> out_regData1=DEADBEEF in the same cycle's update, out_regData2=0, out_EX=4'b1010, out_rd=3. A write to r0 of 32'h1234 then reads r0 as 0.
- Load-use: ex_mem_read=1, ex_rt=2, decoding add r4,r2,r3 -> stall=1 and all out_*=0 next edge. Then ex_mem_read=0 -> stall=0 and the add is issued with out_rd=4.
- No false stall: ex_mem_read=1 with ex_rt=0, or ex_rt=7 with rs=2/rt=3 -> stall=0, normal issue.
- Flush priority: flush=1 together with load-use conditions -> stall=0, all out_*=0.
- Sign extension and beq: IF_ID=64'h00000010_1022FFFF -> out_sign_extended_offset=32'hFFFFFFFF, out_M=3'b100, out_EX=4'b0100, out_WB=0, out_incremented_PC=16. Unknown opcode 0x3F -> control fields all 0.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, 32x32 register file with
// write-first bypass, load-use stall detection and ID/EX pipeline register.
module decode_stage #(
  parameter int          NUM_REGS       = 32,
  parameter logic [31:0] RESET_PC_PLUS4 = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] IF_ID,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        stall,
  output logic [1:0]  out_WB,
  output logic [2:0]  out_M,
  output logic [3:0]  out_EX,
  output logic [31:0] out_incremented_PC,
  output logic [31:0] out_regData1,
  output logic [31:0] out_regData2,
  output logic [31:0] out_sign_extended_offset,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd
);

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [8:0]  ctrl;
  logic [31:0] sext;

  assign instr    = IF_ID[31:0];
  assign pc_plus4 = IF_ID[63:32];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm      = instr[15:0];
  assign sext     = {{16{imm[15]}}, imm};

  // ctrl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite, ALUOp[1:0], RegDst, ALUSrc}
  always_comb begin
    ctrl = 9'b00_000_0000;
    case (op)
      6'h00:   ctrl = 9'b10_000_1010;
      6'h23:   ctrl = 9'b11_010_0001;
      6'h2B:   ctrl = 9'b00_001_0001;
      6'h04:   ctrl = 9'b00_100_0100;
      6'h08:   ctrl = 9'b10_000_0001;
      default: ctrl = 9'b00_000_0000;
    endcase
  end

  // Register file: flop-based because reset must clear every entry.
  logic [31:0] regs_q [NUM_REGS];
  logic        wb_we;

  assign wb_we = wb_reg_write && (wb_write_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we && (32'(wb_write_reg) < NUM_REGS)) begin
      regs_q[wb_write_reg] <= wb_write_data;
    end
  end

  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data [2];

  assign rd_addr[0] = rs;
  assign rd_addr[1] = rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = '0;
        if (rd_addr[gi] == 5'd0) begin
          rd_data[gi] = '0;
        end else if (wb_we && (wb_write_reg == rd_addr[gi])) begin
          rd_data[gi] = wb_write_data;
        end else if (32'(rd_addr[gi]) < NUM_REGS) begin
          rd_data[gi] = regs_q[rd_addr[gi]];
        end
      end
    end
  endgenerate

  // Flush takes priority, so a squashed load-use never reports a stall.
  assign stall = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == rs) || (ex_rt == rt)) && !flush;

  id_ex_t id_ex_q;
  id_ex_t id_ex_d;

  always_comb begin
    id_ex_d = '0;
    if (!flush && !stall) begin
      id_ex_d.wb    = ctrl[8:7];
      id_ex_d.m     = ctrl[6:4];
      id_ex_d.ex    = ctrl[3:0];
      id_ex_d.pc    = pc_plus4;
      id_ex_d.data1 = rd_data[0];
      id_ex_d.data2 = rd_data[1];
      id_ex_d.sext  = sext;
      id_ex_d.rs    = rs;
      id_ex_d.rt    = rt;
      id_ex_d.rd    = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q    <= '0;
      id_ex_q.pc <= RESET_PC_PLUS4;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign out_WB                   = id_ex_q.wb;
  assign out_M                    = id_ex_q.m;
  assign out_EX                   = id_ex_q.ex;
  assign out_incremented_PC       = id_ex_q.pc;
  assign out_regData1             = id_ex_q.data1;
  assign out_regData2             = id_ex_q.data2;
  assign out_sign_extended_offset = id_ex_q.sext;
  assign out_rs                   = id_ex_q.rs;
  assign out_rt                   = id_ex_q.rt;
  assign out_rd                   = id_ex_q.rd;

endmodule
